// File: rtl/bsg_mul_comp42_pkg.sv
// Shared types and helpers for the carry-save 4:2 accumulator.
package bsg_mul_comp42_pkg;

    typedef enum logic {eIDLE, eACCUM} state_e;

    // Increment that sticks at the all-ones value of a w-bit counter (w <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage

// File: rtl/bsg_mul_comp42_row.sv
// Combinational 4:2 compressor row: i[0]+i[1]+i[2]+i[3]+cr_i = s_o + 2*c_o + 2^width_p*cl_o.
module bsg_mul_comp42_row #(
    parameter int width_p  = 32,
    parameter bit harden_p = 1'b0
) (
    input  logic [3:0][width_p-1:0] i,
    input  logic                    cr_i,
    output logic                    cl_o,
    output logic [width_p-1:0]      c_o,
    output logic [width_p-1:0]      s_o
);

    // Lateral carry chain between bit slices; it only ever ripples one position.
    logic [width_p:0] chain;

    assign chain[0] = cr_i;
    assign cl_o     = chain[width_p];

    if (harden_p && (width_p < 5 || width_p > 8)) begin : g_bad_width
        $error("bsg_mul_comp42_row: harden_p=1 requires width_p in 5..8");
    end

    for (genvar k = 0; k < width_p; k++) begin : g_bit
        logic x;
        if (harden_p) begin : g_hard
            // Gate-level equivalent of one cell of the rp comp42 block row.
            assign x            = i[0][k] ^ i[1][k] ^ i[2][k] ^ i[3][k];
            assign chain[k+1]   = (i[0][k] & i[1][k]) | (i[0][k] & i[2][k]) | (i[1][k] & i[2][k]);
            assign s_o[k]       = x ^ chain[k];
            assign c_o[k]       = x ? chain[k] : i[3][k];
        end else begin : g_gen
            // Two cascaded full adders.
            assign x            = i[0][k] ^ i[1][k] ^ i[2][k];
            assign chain[k+1]   = (i[0][k] & i[1][k]) | (i[0][k] & i[2][k]) | (i[1][k] & i[2][k]);
            assign s_o[k]       = x ^ i[3][k] ^ chain[k];
            assign c_o[k]       = (x & i[3][k]) | (x & chain[k]) | (i[3][k] & chain[k]);
        end
    end

endmodule

// File: rtl/bsg_mul_comp42_accum.sv
// Carry-save burst accumulator: one 4:2 row per beat, a single carry-propagate add on the last beat.
module bsg_mul_comp42_accum
    import bsg_mul_comp42_pkg::*;
#(
    parameter int width_p       = 32,
    parameter int count_width_p = 8,
    parameter bit harden_p      = 1'b0
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     v_i,
    output logic                     ready_o,
    input  logic [width_p-1:0]       a_i,
    input  logic [width_p-1:0]       b_i,
    input  logic                     first_i,
    input  logic                     last_i,
    output logic                     v_o,
    input  logic                     yumi_i,
    output logic [width_p-1:0]       data_o,
    output logic [count_width_p-1:0] count_o
);

    state_e                   state_r;
    logic [width_p-1:0]       sum_r, carry_r;
    logic [count_width_p-1:0] cnt_r, cnt_next;
    logic [3:0][width_p-1:0]  row_in;
    logic [width_p-1:0]       row_s, row_c, carry_shift;
    logic                     row_cl_unused;
    logic                     accept, first_beat;

    assign ready_o    = ~v_o | yumi_i;
    assign accept     = v_i & ready_o;
    // An idle block has nothing to merge, so every beat there opens a burst.
    assign first_beat = (state_r == eIDLE) | first_i;

    assign row_in[0] = a_i;
    assign row_in[1] = b_i;
    assign row_in[2] = first_beat ? '0 : sum_r;
    assign row_in[3] = first_beat ? '0 : carry_r;

    bsg_mul_comp42_row #(
        .width_p  (width_p),
        .harden_p (harden_p)
    ) u_row (
        .i    (row_in),
        .cr_i (1'b0),
        .cl_o (row_cl_unused),
        .c_o  (row_c),
        .s_o  (row_s)
    );

    assign carry_shift = row_c << 1;
    assign cnt_next    = first_beat ? count_width_p'(1)
                                    : count_width_p'(sat_inc(32'(cnt_r), count_width_p));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= eIDLE;
            sum_r   <= '0;
            carry_r <= '0;
            cnt_r   <= '0;
            v_o     <= 1'b0;
            data_o  <= '0;
            count_o <= '0;
        end else begin
            if (yumi_i) begin
                v_o <= 1'b0;
            end
            if (accept) begin
                if (last_i) begin
                    data_o  <= row_s + carry_shift;
                    count_o <= cnt_next;
                    v_o     <= 1'b1;
                    sum_r   <= '0;
                    carry_r <= '0;
                    cnt_r   <= '0;
                    state_r <= eIDLE;
                end else begin
                    sum_r   <= row_s;
                    carry_r <= carry_shift;
                    cnt_r   <= cnt_next;
                    state_r <= eACCUM;
                end
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(yumi_i && !v_o))
                else $error("bsg_mul_comp42_accum: yumi_i asserted while v_o=0");
        end
    end
`endif

endmodule
